// File: rtl/caster_pkg.sv
// Shared widths, the column-ID type and the hit counter ceiling for the tag_caster slice.
// Width helpers clamp to 1 so degenerate parameter choices still elaborate.
package caster_pkg;

  function automatic int calc_idw(input int num_col);
    return (num_col > 1) ? $clog2(num_col) : 1;
  endfunction

  function automatic int calc_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int NUM_COL_DEF = 4;
  localparam int IDW_DEF     = calc_idw(NUM_COL_DEF);

  typedef logic [IDW_DEF-1:0] caster_id_t;

  localparam logic [15:0] HIT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/caster_fifo.sv
// Synchronous DEPTH x DATA_WIDTH FIFO; a push is readable at the head the next cycle, no bypass.
// Backpressure: push is ignored when full and pop when empty; flush clears both pointers.
module caster_fifo
  import caster_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int              PTR_W   = calc_ptr_w(DEPTH);
  localparam logic [PTR_W:0]  PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign occupancy = wr_ptr - rd_ptr;
  assign rd_data   = mem[rd_ptr[PTR_W-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= wr_data;
        wr_ptr                 <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/tag_caster.sv
// Per-column multicast receiver: buffers bus words whose tag matches id_i, 1-cycle latency to the PE.
// Backpressure: bus_ready drops only for a matching word while full; CASTER_BCAST_EN adds bcast_i.
module tag_caster
  import caster_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_COL    = 4,
  parameter  int DEPTH      = 4,
  localparam int IDW        = calc_idw(NUM_COL)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IDW-1:0]          id_i,
  input  logic                    caster_en,
  input  logic                    flush,
  input  logic [IDW-1:0]          tag_i,
`ifdef CASTER_BCAST_EN
  input  logic                    bcast_i,
`endif
  input  logic                    bus_valid,
  input  logic [DATA_WIDTH-1:0]   bus_data,
  output logic                    bus_ready,
  output logic                    pe_valid,
  output logic [DATA_WIDTH-1:0]   pe_data,
  input  logic                    pe_ready,
  output logic                    pe_en,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [15:0]             hit_cnt
);

  logic match;
  logic full;
  logic empty;
  logic push;
  logic pop;

`ifdef CASTER_BCAST_EN
  assign match = caster_en & (bcast_i | (tag_i == id_i));
`else
  assign match = caster_en & (tag_i == id_i);
`endif

  // full comes straight from registered pointers, so bus_ready never sees pe_ready.
  assign bus_ready = ~match | ~full;
  assign push      = bus_valid & bus_ready & match & ~flush;
  assign pe_valid  = ~empty;
  assign pop       = pe_valid & pe_ready;
  assign pe_en     = pop;

  caster_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wr_data   (bus_data),
    .rd_data   (pe_data),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (push && (hit_cnt != HIT_CNT_MAX)) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end

endmodule
